// File: rtl/decode_pkg.sv
// Opcode/funct encodings, control-bit indices and the combinational decode function.
// Define FP_DECODE_EN to decode COP1 (opcode 010001) by its rs field; otherwise it is illegal and fp_op stays 0.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLT   = 6'b000110;
  localparam logic [5:0] OP_BGT   = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_COP1  = 6'b010001;
  localparam logic [5:0] OP_BGTE  = 6'b010100;
  localparam logic [5:0] OP_BLTE  = 6'b010101;
  localparam logic [5:0] OP_BGTU  = 6'b010110;
  localparam logic [5:0] OP_BLTU  = 6'b010111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_SLT  = 6'b101010;

  localparam logic [4:0] ALU_NONE = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_ADDU = 5'd2;
  localparam logic [4:0] ALU_SUB  = 5'd3;
  localparam logic [4:0] ALU_SUBU = 5'd4;
  localparam logic [4:0] ALU_AND  = 5'd5;
  localparam logic [4:0] ALU_OR   = 5'd6;
  localparam logic [4:0] ALU_XOR  = 5'd7;
  localparam logic [4:0] ALU_SLT  = 5'd8;
  localparam logic [4:0] ALU_SLL  = 5'd9;
  localparam logic [4:0] ALU_SRL  = 5'd10;
  localparam logic [4:0] ALU_SRA  = 5'd11;
  localparam logic [4:0] ALU_LUI  = 5'd12;

  localparam int CTRL_REG_DST    = 16;
  localparam int CTRL_ALU_SRC    = 15;
  localparam int CTRL_MEM_TO_REG = 14;
  localparam int CTRL_REG_WRITE  = 13;
  localparam int CTRL_MEM_READ   = 12;
  localparam int CTRL_MEM_WRITE  = 11;
  localparam int CTRL_BR_EQ      = 10;
  localparam int CTRL_BR_NE      = 9;
  localparam int CTRL_BR_GT      = 8;
  localparam int CTRL_BR_GTE     = 7;
  localparam int CTRL_BR_LT      = 6;
  localparam int CTRL_BR_LTE     = 5;
  localparam int CTRL_BR_GTU     = 4;
  localparam int CTRL_BR_LTU     = 3;
  localparam int CTRL_JUMP       = 2;
  localparam int CTRL_JUMP_REG   = 1;
  localparam int CTRL_LINK       = 0;

  localparam logic [4:0] FP_RS_MFC1 = 5'b00000;
  localparam logic [4:0] FP_RS_MTC1 = 5'b00100;
  localparam logic [4:0] FP_RS_ADD  = 5'b10000;
  localparam logic [4:0] FP_RS_SUB  = 5'b10001;
  localparam logic [4:0] FP_RS_MOV  = 5'b11010;
  localparam logic [4:0] FP_RS_CEQ  = 5'b11000;
  localparam logic [4:0] FP_RS_CLE  = 5'b11001;
  localparam logic [4:0] FP_RS_CLT  = 5'b11100;

  localparam logic [2:0] FP_MFC1 = 3'd0;
  localparam logic [2:0] FP_MTC1 = 3'd1;
  localparam logic [2:0] FP_ADD  = 3'd2;
  localparam logic [2:0] FP_SUB  = 3'd3;
  localparam logic [2:0] FP_MOV  = 3'd4;
  localparam logic [2:0] FP_CEQ  = 3'd5;
  localparam logic [2:0] FP_CLE  = 3'd6;
  localparam logic [2:0] FP_CLT  = 3'd7;

  typedef struct packed {
    logic [16:0] ctrl;
    logic [4:0]  alu;
    logic        illegal;
    logic [2:0]  fp_op;
    logic        rd31;
    logic        uses_rs;
    logic        uses_rt;
  } dec_t;

  function automatic dec_t decode_instr(input logic [31:0] instr);
    dec_t       d;
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    op    = instr[31:26];
    funct = instr[5:0];
    rs    = instr[25:21];
    d     = '0;
    case (op)
      OP_RTYPE: begin
        d.uses_rs = 1'b1;
        d.uses_rt = 1'b1;
        case (funct)
          F_ADD:   d.alu = ALU_ADD;
          F_ADDU:  d.alu = ALU_ADDU;
          F_SUB:   d.alu = ALU_SUB;
          F_SUBU:  d.alu = ALU_SUBU;
          F_AND:   d.alu = ALU_AND;
          F_OR:    d.alu = ALU_OR;
          F_XOR:   d.alu = ALU_XOR;
          F_SLT:   d.alu = ALU_SLT;
          F_SLL:   d.alu = ALU_SLL;
          F_SRL:   d.alu = ALU_SRL;
          F_SRA:   d.alu = ALU_SRA;
          F_JR:    d.ctrl[CTRL_JUMP_REG] = 1'b1;
          default: d.illegal = 1'b1;
        endcase
        // Every ALU-type funct writes rd; jr and illegal functs leave alu at zero.
        if (d.alu != ALU_NONE) begin
          d.ctrl[CTRL_REG_DST]   = 1'b1;
          d.ctrl[CTRL_REG_WRITE] = 1'b1;
        end
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI: begin
        d.ctrl[CTRL_ALU_SRC]   = 1'b1;
        d.ctrl[CTRL_REG_WRITE] = 1'b1;
        d.uses_rs = (op != OP_LUI);
        case (op)
          OP_ADDI:  d.alu = ALU_ADD;
          OP_ADDIU: d.alu = ALU_ADDU;
          OP_ANDI:  d.alu = ALU_AND;
          OP_ORI:   d.alu = ALU_OR;
          OP_XORI:  d.alu = ALU_XOR;
          OP_SLTI:  d.alu = ALU_SLT;
          default:  d.alu = ALU_LUI;
        endcase
      end
      OP_LW: begin
        d.ctrl[CTRL_ALU_SRC]    = 1'b1;
        d.ctrl[CTRL_MEM_TO_REG] = 1'b1;
        d.ctrl[CTRL_REG_WRITE]  = 1'b1;
        d.ctrl[CTRL_MEM_READ]   = 1'b1;
        d.alu     = ALU_ADD;
        d.uses_rs = 1'b1;
      end
      OP_SW: begin
        d.ctrl[CTRL_ALU_SRC]   = 1'b1;
        d.ctrl[CTRL_MEM_WRITE] = 1'b1;
        d.alu     = ALU_ADD;
        d.uses_rs = 1'b1;
        d.uses_rt = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BGT, OP_BGTE, OP_BLT, OP_BLTE, OP_BGTU, OP_BLTU: begin
        d.alu     = ALU_SUB;
        d.uses_rs = 1'b1;
        d.uses_rt = 1'b1;
        case (op)
          OP_BEQ:  d.ctrl[CTRL_BR_EQ]  = 1'b1;
          OP_BNE:  d.ctrl[CTRL_BR_NE]  = 1'b1;
          OP_BGT:  d.ctrl[CTRL_BR_GT]  = 1'b1;
          OP_BGTE: d.ctrl[CTRL_BR_GTE] = 1'b1;
          OP_BLT:  d.ctrl[CTRL_BR_LT]  = 1'b1;
          OP_BLTE: d.ctrl[CTRL_BR_LTE] = 1'b1;
          OP_BGTU: d.ctrl[CTRL_BR_GTU] = 1'b1;
          default: d.ctrl[CTRL_BR_LTU] = 1'b1;
        endcase
      end
      OP_J: d.ctrl[CTRL_JUMP] = 1'b1;
      OP_JAL: begin
        d.ctrl[CTRL_JUMP]      = 1'b1;
        d.ctrl[CTRL_LINK]      = 1'b1;
        d.ctrl[CTRL_REG_WRITE] = 1'b1;
        d.rd31 = 1'b1;
      end
`ifdef FP_DECODE_EN
      OP_COP1: begin
        case (rs)
          FP_RS_MFC1: begin
            d.fp_op = FP_MFC1;
            d.ctrl[CTRL_REG_DST]   = 1'b1;
            d.ctrl[CTRL_REG_WRITE] = 1'b1;
          end
          FP_RS_MTC1: d.fp_op = FP_MTC1;
          FP_RS_ADD:  d.fp_op = FP_ADD;
          FP_RS_SUB:  d.fp_op = FP_SUB;
          FP_RS_MOV:  d.fp_op = FP_MOV;
          FP_RS_CEQ:  d.fp_op = FP_CEQ;
          FP_RS_CLE:  d.fp_op = FP_CLE;
          FP_RS_CLT:  d.fp_op = FP_CLT;
          default:    d.illegal = 1'b1;
        endcase
      end
`else
      OP_COP1: d.illegal = (rs == rs);
`endif
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Parametrised synchronous FIFO with wrap-bit pointers and a flush that empties it at the next edge.
module instr_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign rdata     = mem_r[rd_ptr_r[AW-1:0]];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Pointer update; flush outranks any push or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush && !rst) mem_r[wr_ptr_r[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/decode_stage.sv
// Flow-controlled decode stage: instr_fifo buffers fetch, head is decoded into a registered bundle.
// Macro FP_DECODE_EN (see decode_pkg) adds COP1 decode; without it out_fp_op is constant zero.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2,
  parameter int ALU_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_shamt,
  output logic [XLEN-1:0]  out_imm_se,
  output logic [XLEN-1:0]  out_imm_ze,
  output logic [25:0]      out_addr26,
  output logic [16:0]      out_ctrl,
  output logic [ALU_W-1:0] out_alu_ctrl,
  output logic             out_illegal,
  output logic [2:0]       out_fp_op,
  output logic             stall
);
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              push_s;
  logic [2*XLEN-1:0] head_s;
  logic [XLEN-1:0]   head_instr_s;
  logic [XLEN-1:0]   head_pc_s;
  dec_t              dec_s;
  logic              hazard_s;
  logic              slot_free_s;
  logic              load_s;

  logic              out_valid_r;
  logic              stall_r;
  logic [XLEN-1:0]   out_pc_r;
  logic [4:0]        out_rs_r;
  logic [4:0]        out_rt_r;
  logic [4:0]        out_rd_r;
  logic [4:0]        out_shamt_r;
  logic [XLEN-1:0]   out_imm_se_r;
  logic [XLEN-1:0]   out_imm_ze_r;
  logic [25:0]       out_addr26_r;
  logic [16:0]       out_ctrl_r;
  logic [ALU_W-1:0]  out_alu_ctrl_r;
  logic              out_illegal_r;
  logic [2:0]        out_fp_op_r;

  assign in_ready = !fifo_full_s;
  assign push_s   = in_valid && !fifo_full_s;

  instr_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push_s),
    .pop   (load_s),
    .wdata ({in_instr, in_pc}),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign head_instr_s = head_s[2*XLEN-1:XLEN];
  assign head_pc_s    = head_s[XLEN-1:0];
  assign dec_s        = decode_instr(head_instr_s[31:0]);
  assign slot_free_s  = !out_valid_r || out_ready;
  assign load_s       = !fifo_empty_s && slot_free_s && !hazard_s;

  // Load-use check: the head reads a register the load in execute has not produced yet.
  always_comb begin
    hazard_s = 1'b0;
    if (ex_mem_read && (ex_rt != 5'd0) && !fifo_empty_s) begin
      hazard_s = (dec_s.uses_rs && (head_instr_s[25:21] == ex_rt)) ||
                 (dec_s.uses_rt && (head_instr_s[20:16] == ex_rt));
    end else begin
      hazard_s = 1'b0;
    end
  end

  // Output bundle register and stall flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r    <= 1'b0;
      stall_r        <= 1'b0;
      out_pc_r       <= '0;
      out_rs_r       <= '0;
      out_rt_r       <= '0;
      out_rd_r       <= '0;
      out_shamt_r    <= '0;
      out_imm_se_r   <= '0;
      out_imm_ze_r   <= '0;
      out_addr26_r   <= '0;
      out_ctrl_r     <= '0;
      out_alu_ctrl_r <= '0;
      out_illegal_r  <= 1'b0;
      out_fp_op_r    <= '0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
      stall_r     <= 1'b0;
    end else begin
      stall_r <= hazard_s && slot_free_s;
      if (load_s) begin
        out_valid_r    <= 1'b1;
        out_pc_r       <= head_pc_s;
        out_rs_r       <= head_instr_s[25:21];
        out_rt_r       <= head_instr_s[20:16];
        out_rd_r       <= dec_s.rd31 ? 5'd31 : head_instr_s[15:11];
        out_shamt_r    <= head_instr_s[10:6];
        out_imm_se_r   <= {{(XLEN-16){head_instr_s[15]}}, head_instr_s[15:0]};
        out_imm_ze_r   <= {{(XLEN-16){1'b0}}, head_instr_s[15:0]};
        out_addr26_r   <= head_instr_s[25:0];
        out_ctrl_r     <= dec_s.ctrl;
        out_alu_ctrl_r <= ALU_W'(dec_s.alu);
        out_illegal_r  <= dec_s.illegal;
        out_fp_op_r    <= dec_s.fp_op;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign out_valid    = out_valid_r;
  assign stall        = stall_r;
  assign out_pc       = out_pc_r;
  assign out_rs       = out_rs_r;
  assign out_rt       = out_rt_r;
  assign out_rd       = out_rd_r;
  assign out_shamt    = out_shamt_r;
  assign out_imm_se   = out_imm_se_r;
  assign out_imm_ze   = out_imm_ze_r;
  assign out_addr26   = out_addr26_r;
  assign out_ctrl     = out_ctrl_r;
  assign out_alu_ctrl = out_alu_ctrl_r;
  assign out_illegal  = out_illegal_r;
  assign out_fp_op    = out_fp_op_r;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vector table plus backpressure, stall, flush and reset sequences.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, ex_mem_read, out_valid, out_ready, out_illegal, stall;
  logic [31:0] in_instr, in_pc, out_pc, out_imm_se, out_imm_ze;
  logic [4:0]  ex_rt, out_rs, out_rt, out_rd, out_shamt, out_alu_ctrl;
  logic [25:0] out_addr26;
  logic [16:0] out_ctrl;
  logic [2:0]  out_fp_op;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rs(out_rs),
    .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt), .out_imm_se(out_imm_se),
    .out_imm_ze(out_imm_ze), .out_addr26(out_addr26), .out_ctrl(out_ctrl),
    .out_alu_ctrl(out_alu_ctrl), .out_illegal(out_illegal), .out_fp_op(out_fp_op), .stall(stall)
  );

  typedef struct {
    logic [31:0] instr;
    logic [16:0] ctrl;
    logic [4:0]  alu;
    logic        ill;
    logic [4:0]  rd;
    logic [31:0] imm_se;
    logic [31:0] imm_ze;
    logic [2:0]  fp;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; ex_mem_read = 1'b0;
    repeat (3) tick();
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    tick();
  endtask

  initial begin
    int cnt;
    logic [31:0] ins;
    vecs[0]  = '{32'h00221820, 17'h12000, 5'd1,  1'b0, 5'd3,  32'h00001820, 32'h00001820, 3'd0};
    vecs[1]  = '{32'h00C72822, 17'h12000, 5'd3,  1'b0, 5'd5,  32'h00002822, 32'h00002822, 3'd0};
    vecs[2]  = '{32'h000220C3, 17'h12000, 5'd11, 1'b0, 5'd4,  32'h000020C3, 32'h000020C3, 3'd0};
    vecs[3]  = '{32'h03E00008, 17'h00002, 5'd0,  1'b0, 5'd0,  32'h00000008, 32'h00000008, 3'd0};
    vecs[4]  = '{32'h0000003F, 17'h00000, 5'd0,  1'b1, 5'd0,  32'h0000003F, 32'h0000003F, 3'd0};
    vecs[5]  = '{32'h2022FFFF, 17'h0A000, 5'd1,  1'b0, 5'd31, 32'hFFFFFFFF, 32'h0000FFFF, 3'd0};
    vecs[6]  = '{32'h3C011234, 17'h0A000, 5'd12, 1'b0, 5'd2,  32'h00001234, 32'h00001234, 3'd0};
    vecs[7]  = '{32'h8C850008, 17'h0F000, 5'd1,  1'b0, 5'd0,  32'h00000008, 32'h00000008, 3'd0};
    vecs[8]  = '{32'hAC850000, 17'h08800, 5'd1,  1'b0, 5'd0,  32'h00000000, 32'h00000000, 3'd0};
    vecs[9]  = '{32'h50220010, 17'h00080, 5'd3,  1'b0, 5'd0,  32'h00000010, 32'h00000010, 3'd0};
    vecs[10] = '{32'h5C22FFFC, 17'h00008, 5'd3,  1'b0, 5'd31, 32'hFFFFFFFC, 32'h0000FFFC, 3'd0};
    vecs[11] = '{32'h0C000100, 17'h02005, 5'd0,  1'b0, 5'd31, 32'h00000100, 32'h00000100, 3'd0};
    vecs[12] = '{32'hFC001234, 17'h00000, 5'd0,  1'b1, 5'd2,  32'h00001234, 32'h00001234, 3'd0};
`ifdef FP_DECODE_EN
    vecs[13] = '{32'h46020000, 17'h00000, 5'd0,  1'b0, 5'd0,  32'h00000000, 32'h00000000, 3'd2};
`else
    vecs[13] = '{32'h46020000, 17'h00000, 5'd0,  1'b1, 5'd0,  32'h00000000, 32'h00000000, 3'd0};
`endif
    vecs[14] = '{32'h08000040, 17'h00004, 5'd0,  1'b0, 5'd0,  32'h00000040, 32'h00000040, 3'd0};
    vecs[15] = '{32'h10220004, 17'h00400, 5'd3,  1'b0, 5'd0,  32'h00000004, 32'h00000004, 3'd0};

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
    ex_mem_read = 1'b0; ex_rt = '0; out_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst stall", 64'(stall), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst out_pc", 64'(out_pc), 64'd0);
    chk("rst alu", 64'(out_alu_ctrl), 64'd0);

    // Each word is pushed at one edge and must be on the outputs after the next.
    for (int i = 0; i < 16; i++) begin
      ins = vecs[i].instr;
      push(ins, 32'h100 + 32'(4 * i));
      in_valid = 1'b0;
      tick();
      chk($sformatf("v%0d valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d pc", i), 64'(out_pc), 64'(32'h100 + 32'(4 * i)));
      chk($sformatf("v%0d ctrl", i), 64'(out_ctrl), 64'(vecs[i].ctrl));
      chk($sformatf("v%0d alu", i), 64'(out_alu_ctrl), 64'(vecs[i].alu));
      chk($sformatf("v%0d illegal", i), 64'(out_illegal), 64'(vecs[i].ill));
      chk($sformatf("v%0d rd", i), 64'(out_rd), 64'(vecs[i].rd));
      chk($sformatf("v%0d imm_se", i), 64'(out_imm_se), 64'(vecs[i].imm_se));
      chk($sformatf("v%0d imm_ze", i), 64'(out_imm_ze), 64'(vecs[i].imm_ze));
      chk($sformatf("v%0d fp_op", i), 64'(out_fp_op), 64'(vecs[i].fp));
      chk($sformatf("v%0d rs", i), 64'(out_rs), 64'(ins[25:21]));
      chk($sformatf("v%0d rt", i), 64'(out_rt), 64'(ins[20:16]));
      chk($sformatf("v%0d addr26", i), 64'(out_addr26), 64'(ins[25:0]));
    end

    // Load-use: sw $5,0($4) behind a load to $5 is held one cycle.
    drain();
    ex_mem_read = 1'b1; ex_rt = 5'd5;
    push(32'hAC850000, 32'h300);
    in_valid = 1'b0;
    tick();
    chk("hz stall", 64'(stall), 64'd1);
    chk("hz out_valid", 64'(out_valid), 64'd0);
    ex_mem_read = 1'b0;
    tick();
    chk("hz deliver valid", 64'(out_valid), 64'd1);
    chk("hz deliver ctrl", 64'(out_ctrl), 64'h08800);
    chk("hz deliver stall", 64'(stall), 64'd0);

    // A load to an unrelated register must not stall.
    drain();
    ex_mem_read = 1'b1; ex_rt = 5'd6;
    push(32'hAC850000, 32'h304);
    in_valid = 1'b0;
    tick();
    chk("nohz valid", 64'(out_valid), 64'd1);
    chk("nohz stall", 64'(stall), 64'd0);
    ex_mem_read = 1'b0;

    // Backpressure: output slot plus two FIFO entries, then drained in order.
    drain();
    out_ready = 1'b0;
    push(32'h00221820, 32'h200);
    push(32'h00221820, 32'h204);
    chk("bp in_ready mid", 64'(in_ready), 64'd1);
    push(32'h00221820, 32'h208);
    in_valid = 1'b0;
    chk("bp in_ready full", 64'(in_ready), 64'd0);
    chk("bp head valid", 64'(out_valid), 64'd1);
    chk("bp word0", 64'(out_pc), 64'h200);
    out_ready = 1'b1;
    tick();
    chk("bp word1 valid", 64'(out_valid), 64'd1);
    chk("bp word1", 64'(out_pc), 64'h204);
    chk("bp in_ready free", 64'(in_ready), 64'd1);
    tick();
    chk("bp word2 valid", 64'(out_valid), 64'd1);
    chk("bp word2", 64'(out_pc), 64'h208);
    tick();
    chk("bp empty", 64'(out_valid), 64'd0);

    // Flush with a word in the slot, one buffered, and a simultaneous push.
    drain();
    out_ready = 1'b0;
    push(32'h00221820, 32'h400);
    push(32'h00221820, 32'h404);
    chk("fl pre in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_instr = 32'h00221820; in_pc = 32'h408; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl out_valid", 64'(out_valid), 64'd0);
    chk("fl in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    cnt = 0;
    repeat (4) begin
      tick();
      if (out_valid) cnt++;
    end
    chk("fl nothing emerges", 64'(cnt), 64'd0);

    // Reset in the middle of a transfer drops everything.
    drain();
    out_ready = 1'b0;
    push(32'h00221820, 32'h500);
    push(32'h00221820, 32'h504);
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst out_valid", 64'(out_valid), 64'd0);
    chk("mrst in_ready", 64'(in_ready), 64'd1);
    chk("mrst out_pc", 64'(out_pc), 64'd0);
    out_ready = 1'b1;
    cnt = 0;
    repeat (3) begin
      tick();
      if (out_valid) cnt++;
    end
    chk("mrst nothing emerges", 64'(cnt), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
